tm_lif_sched: RTL

Scheduler for a time-multiplexed leaky-integrate-and-fire (LIF) neuron array. One shared update datapath serves N_NEURONS neurons. The block keeps per-neuron membrane state and thresholds, fetches one input current per neuron through a valid/ready handshake, and updates neurons in index order. After the last neuron it publishes the spike vector for that timestep. It sits between the input-current source and the downstream spike consumer, and replaces free-running per-neuron update logic with a sequenced, stallable timestep.

---
 rtl/tm_lif_sched.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/tm_lif_sched.sv
// tm_lif_sched: sequenced scheduler for a time-multiplexed LIF neuron array.
// A single add/leak/compare datapath visits each neuron in index order. One
// input current is fetched per neuron through a valid/ready handshake, and the
// spike vector is published once the last neuron has been updated.
module tm_lif_sched #(
  parameter int N_NEURONS      = 8,
  parameter int WIDTH          = 8,
  parameter int DEFAULT_THRESH = 127,
  parameter int LEAK_SHIFT     = 1,
  localparam int IDX_W         = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_current,
  output logic                 in_ready,
  output logic [IDX_W-1:0]     in_idx,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_addr,
  input  logic [WIDTH-1:0]     cfg_thresh,
  output logic                 busy,
  output logic [N_NEURONS-1:0] spike_vec,
  output logic                 spike_valid,
  output logic [WIDTH-1:0]     mem_out
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_UPDATE = 2'd2,
    S_DONE   = 2'd3
  } fsm_t;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_NEURONS - 1);
  localparam logic [WIDTH-1:0] THRESH_RST = WIDTH'(DEFAULT_THRESH);

  fsm_t                 fsm_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [WIDTH-1:0]     cur_reg;
  logic [WIDTH-1:0]     mem_out_reg;
  logic                 in_ready_reg;
  logic                 busy_reg;
  logic                 spike_valid_reg;
  logic [N_NEURONS-1:0] spike_vec_reg;

  // Per-neuron storage gathered into buses for the shared datapath.
  logic [N_NEURONS-1:0][WIDTH-1:0] mem_bus;
  logic [N_NEURONS-1:0][WIDTH-1:0] thresh_bus;
  logic [N_NEURONS-1:0]            spike_acc_bus;

  // Shared datapath signals for the neuron currently selected by idx_reg.
  logic [WIDTH:0]       sum_wide;
  logic [WIDTH-1:0]     sum_sat;
  logic                 spike_next;
  logic [WIDTH-1:0]     mem_next;
  logic [N_NEURONS-1:0] acc_next;

  logic start_accept;
  logic cfg_accept;
  logic update_fire;

  // Start and threshold writes are only honoured while idle, so the threshold
  // set cannot change in the middle of a timestep.
  assign start_accept = (fsm_reg == S_IDLE) && start;
  assign cfg_accept   = (fsm_reg == S_IDLE) && cfg_we;
  assign update_fire  = (fsm_reg == S_UPDATE);

  // One extra bit catches the carry so the sum can saturate instead of wrap.
  assign sum_wide   = {1'b0, cur_reg} + ({1'b0, mem_bus[idx_reg]} >> LEAK_SHIFT);
  assign sum_sat    = sum_wide[WIDTH] ? {WIDTH{1'b1}} : sum_wide[WIDTH-1:0];
  assign spike_next = (sum_sat >= thresh_bus[idx_reg]);
  assign mem_next   = spike_next ? '0 : sum_sat;

  // The last neuron's spike bit is written on the same edge the vector is
  // published, so merge it in here rather than reading the stale accumulator.
  assign acc_next = spike_acc_bus | (N_NEURONS'(spike_next) << idx_reg);

  for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
    logic [WIDTH-1:0] mem_reg;
    logic [WIDTH-1:0] thresh_reg;
    logic             spike_acc_reg;
    logic             sel;

    assign sel = (idx_reg == IDX_W'(gi));

    // Membrane, threshold and spike-accumulator bit for this neuron.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_reg       <= '0;
        thresh_reg    <= THRESH_RST;
        spike_acc_reg <= 1'b0;
      end else begin
        if (cfg_accept && (cfg_addr == IDX_W'(gi))) begin
          thresh_reg <= cfg_thresh;
        end
        if (update_fire && sel) begin
          mem_reg       <= mem_next;
          spike_acc_reg <= spike_next;
        end else if (start_accept) begin
          spike_acc_reg <= 1'b0;
        end
      end
    end

    assign mem_bus[gi]       = mem_reg;
    assign thresh_bus[gi]    = thresh_reg;
    assign spike_acc_bus[gi] = spike_acc_reg;
  end

  // Timestep sequencer with all handshake and status outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg         <= S_IDLE;
      idx_reg         <= '0;
      cur_reg         <= '0;
      mem_out_reg     <= '0;
      in_ready_reg    <= 1'b0;
      busy_reg        <= 1'b0;
      spike_valid_reg <= 1'b0;
      spike_vec_reg   <= '0;
    end else begin
      spike_valid_reg <= 1'b0;
      case (fsm_reg)
        S_IDLE: begin
          if (start) begin
            fsm_reg      <= S_FETCH;
            idx_reg      <= '0;
            in_ready_reg <= 1'b1;
            busy_reg     <= 1'b1;
          end
        end
        S_FETCH: begin
          if (in_valid && in_ready_reg) begin
            cur_reg      <= in_current;
            in_ready_reg <= 1'b0;
            fsm_reg      <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          mem_out_reg <= mem_next;
          if (idx_reg == LAST_IDX) begin
            fsm_reg         <= S_DONE;
            spike_vec_reg   <= acc_next;
            spike_valid_reg <= 1'b1;
          end else begin
            idx_reg      <= idx_reg + IDX_W'(1);
            in_ready_reg <= 1'b1;
            fsm_reg      <= S_FETCH;
          end
        end
        S_DONE: begin
          fsm_reg  <= S_IDLE;
          busy_reg <= 1'b0;
        end
        default: begin
          fsm_reg      <= S_IDLE;
          in_ready_reg <= 1'b0;
          busy_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_reg;
  assign in_idx      = idx_reg;
  assign busy        = busy_reg;
  assign spike_vec   = spike_vec_reg;
  assign spike_valid = spike_valid_reg;
  assign mem_out     = mem_out_reg;

endmodule
